// File: rtl/bus_timer.sv
// bus_timer: memory-mapped prescaled interval timer with READY/OVERRUN flags; define BUS_TIMER_IRQ_EN to add IE bit and irq output
module bus_timer #(
  parameter int BITS = 32,
  parameter logic [BITS-1:0] BASE_COUNT = 32'hF0000020,
  parameter logic [BITS-1:0] BASE_LIMIT = 32'hF0000024,
  parameter logic [BITS-1:0] BASE_CONTROL = 32'hF0000120,
  parameter int PRESCALE = 25000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [BITS-1:0] memAddr,
  input  logic [BITS-1:0] dataBusIn,
  output logic [BITS-1:0] dataBusOut
`ifdef BUS_TIMER_IRQ_EN
  ,
  output logic            irq
`endif
);
  localparam int PW = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);
  logic [PW-1:0] ps;
  logic [BITS-1:0] count, limit;
  logic [BITS:0] countInc;
  logic ready, overrun, ie;
  logic tick, wrCount, wrLimit, wrControl, clrReady, clrOverrun, wrap;
  logic [2:0] control;
  // decode bus writes and detect tick / wrap; the increment is one bit wider so COUNT=max still compares correctly
  always_comb begin
    tick = ps == PS_MAX;
    wrCount = we && memAddr == BASE_COUNT;
    wrLimit = we && memAddr == BASE_LIMIT;
    wrControl = we && memAddr == BASE_CONTROL;
    clrReady = wrControl && !dataBusIn[0];
    clrOverrun = wrControl && !dataBusIn[1];
    countInc = {1'b0, count} + (BITS+1)'(1);
    wrap = tick && !wrCount && limit != '0 && countInc >= {1'b0, limit};
    control = {ie, overrun, ready};
  end
  // prescaler and counter; a COUNT write overrides any tick and restarts the prescaler
  always_ff @(posedge clk) begin
    if (reset) begin
      ps <= '0;
      count <= '0;
    end else begin
      ps <= (wrCount || tick) ? '0 : ps + PW'(1);
      count <= wrCount ? dataBusIn : wrap ? '0 : tick ? countInc[BITS-1:0] : count;
    end
  end
  // limit register
  always_ff @(posedge clk) begin
    if (reset) limit <= '0;
    else if (wrLimit) limit <= dataBusIn;
  end
  // status flags: wrap sets, write-zero clears, set wins over clear
  always_ff @(posedge clk) begin
    if (reset) begin
      ready <= 1'b0;
      overrun <= 1'b0;
    end else begin
      ready <= wrap || (ready && !clrReady);
      overrun <= (wrap && ready && !clrReady) || (overrun && !clrOverrun);
    end
  end
`ifdef BUS_TIMER_IRQ_EN
  // interrupt enable (plain read/write) and registered interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      ie <= 1'b0;
      irq <= 1'b0;
    end else begin
      ie <= wrControl ? dataBusIn[2] : ie;
      irq <= ready && ie;
    end
  end
`else
  assign ie = 1'b0;
`endif
  // zero-latency read mux, all-zero when not addressed so it can be ORed onto the bus
  always_comb begin
    dataBusOut = we ? '0
      : memAddr == BASE_COUNT ? count
      : memAddr == BASE_LIMIT ? limit
      : memAddr == BASE_CONTROL ? BITS'(control)
      : '0;
  end
endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed self-checking bench for bus_timer (PRESCALE=4 and PRESCALE=1 instances)
module tb_bus_timer;
  localparam logic [31:0] A_COUNT = 32'hF0000020;
  localparam logic [31:0] A_LIMIT = 32'hF0000024;
  localparam logic [31:0] A_CTRL = 32'hF0000120;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic we = 1'b0, we1 = 1'b0;
  logic [31:0] memAddr = '0, dataBusIn = '0, dataBusOut;
  logic [31:0] memAddr1 = '0, dataBusIn1 = '0, dataBusOut1;
  int checks = 0;
  int errors = 0;
`ifdef BUS_TIMER_IRQ_EN
  logic irq, irq1;
`endif
  bus_timer #(.PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .we(we), .memAddr(memAddr), .dataBusIn(dataBusIn), .dataBusOut(dataBusOut)
`ifdef BUS_TIMER_IRQ_EN
    , .irq(irq)
`endif
  );
  bus_timer #(.PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .we(we1), .memAddr(memAddr1), .dataBusIn(dataBusIn1), .dataBusOut(dataBusOut1)
`ifdef BUS_TIMER_IRQ_EN
    , .irq(irq1)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; memAddr = a; dataBusIn = d;
    @(posedge clk);
    #1;
    we = 1'b0; memAddr = '0; dataBusIn = '0;
  endtask
  task automatic wr1(input logic [31:0] a, input logic [31:0] d);
    we1 = 1'b1; memAddr1 = a; dataBusIn1 = d;
    @(posedge clk);
    #1;
    we1 = 1'b0; memAddr1 = '0; dataBusIn1 = '0;
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    memAddr = a;
    #1;
    chk(tag, dataBusOut, exp);
    memAddr = '0;
  endtask
  task automatic rd1(input logic [31:0] a, input logic [31:0] exp, input string tag);
    memAddr1 = a;
    #1;
    chk(tag, dataBusOut1, exp);
    memAddr1 = '0;
  endtask
  initial begin
    cyc(3);
    reset = 1'b0;
    cyc(40);
    rd(A_COUNT, 32'd10, "idleCount40");
    rd(A_LIMIT, 32'd0, "resetLimit");
    rd(A_CTRL, 32'd0, "resetControl");
    rd(32'hF0000004, 32'd0, "unmappedRead");
    wr(A_LIMIT, 32'd3);
    wr(A_COUNT, 32'd0);
    rd(A_COUNT, 32'd0, "countAfterWrite");
    cyc(4);
    rd(A_COUNT, 32'd1, "seqCount1");
    cyc(4);
    rd(A_COUNT, 32'd2, "seqCount2");
    cyc(3);
    rd(A_CTRL, 32'd0, "readyBeforeWrap");
    cyc(1);
    rd(A_COUNT, 32'd0, "seqWrap0");
    rd(A_CTRL, 32'd1, "readyAfterWrap");
    cyc(12);
    rd(A_CTRL, 32'd3, "overrunSecondWrap");
    wr(A_CTRL, 32'd0);
    rd(A_CTRL, 32'd0, "clearAll");
    cyc(10);
    wr(A_CTRL, 32'd0);
    rd(A_CTRL, 32'd1, "readySetWins");
    cyc(11);
    wr(A_CTRL, 32'd2);
    rd(A_CTRL, 32'd1, "noOverrunWhenClearing");
    cyc(11);
    wr(A_CTRL, 32'd1);
    rd(A_CTRL, 32'd3, "overrunSetWins");
    wr(A_COUNT, 32'd10);
    wr(A_LIMIT, 32'd5);
    cyc(2);
    rd(A_COUNT, 32'd10, "countAboveLimitHeld");
    cyc(1);
    rd(A_COUNT, 32'd0, "countAboveLimitWraps");
    we = 1'b1; memAddr = A_COUNT;
    #1;
    chk("readDuringWrite", dataBusOut, 32'd0);
    we = 1'b0; memAddr = '0;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    rd(A_COUNT, 32'd0, "midResetCount");
    rd(A_LIMIT, 32'd0, "midResetLimit");
    rd(A_CTRL, 32'd0, "midResetControl");
    cyc(4);
    rd(A_COUNT, 32'd1, "resumeAfterReset");
    cyc(3);
    wr(A_COUNT, 32'd7);
    cyc(3);
    rd(A_COUNT, 32'd7, "countWriteOverTick");
    cyc(1);
    rd(A_COUNT, 32'd8, "countAfterOverride");
    wr1(A_COUNT, 32'hFFFFFFFF);
    rd1(A_COUNT, 32'hFFFFFFFF, "ps1CountMax");
    cyc(1);
    rd1(A_COUNT, 32'd0, "ps1FreeRunRollover");
    rd1(A_CTRL, 32'd0, "ps1NoWrapEvent");
    wr1(A_COUNT, 32'd7);
    rd1(A_COUNT, 32'd7, "ps1WriteOverTick");
    cyc(1);
    rd1(A_COUNT, 32'd8, "ps1NextTick");
`ifdef BUS_TIMER_IRQ_EN
    begin
      int n = 0;
      wr(A_CTRL, 32'd4);
      rd(A_CTRL, 32'd4, "ieSet");
      wr(A_LIMIT, 32'd2);
      memAddr = A_CTRL;
      #1;
      while (!dataBusOut[0] && n < 20) begin
        cyc(1);
        memAddr = A_CTRL;
        #1;
        n++;
      end
      memAddr = '0;
      chk("readyTimeout", 32'(n < 20), 32'd1);
      chk("irqLowWithReady", {31'd0, irq}, 32'd0);
      cyc(1);
      chk("irqRises", {31'd0, irq}, 32'd1);
      wr(A_CTRL, 32'd4);
      rd(A_CTRL, 32'd4, "readyClearedIeKept");
      chk("irqStillHigh", {31'd0, irq}, 32'd1);
      cyc(1);
      chk("irqFalls", {31'd0, irq}, 32'd0);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      rd(A_COUNT, 32'd0, "irqResetCount");
      rd(A_CTRL, 32'd0, "irqResetIe");
      chk("irqResetIrq", {31'd0, irq}, 32'd0);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
